ahb_lite_arbiter_n: RTL and testbench

//  N-master AHB-Lite arbiter/mux; parametrised successor to the fixed 2-master core/debugger mux.

---
 rtl/ahb_lite_arbiter_n.sv | 134 +++++++++++++
 tb/tb_ahb_lite_arbiter_n.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_arbiter_n.sv
`default_nettype none
// ahb_lite_arbiter_n: N-master AHB-Lite arbiter/mux, fixed-priority or round-robin,
// handover only at owner-IDLE boundaries, data-phase ownership tracked separately.
module ahb_lite_arbiter_n #(
   parameter int NUM_MASTERS  = 2,
   parameter int ARB_MODE     = 0,
   parameter int PARK_MASTER  = 0,
   parameter int FORCE_MASTER = 1,
   parameter int GW           = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       force_req,
   input  logic [2*NUM_MASTERS-1:0]   HTRANS_M,
   input  logic [32*NUM_MASTERS-1:0]  HADDR_M,
   input  logic [32*NUM_MASTERS-1:0]  HWDATA_M,
   input  logic [NUM_MASTERS-1:0]     HWRITE_M,
   input  logic [3*NUM_MASTERS-1:0]   HSIZE_M,
   input  logic [3*NUM_MASTERS-1:0]   HBURST_M,
   input  logic [4*NUM_MASTERS-1:0]   HPROT_M,
   input  logic [NUM_MASTERS-1:0]     HMASTLOCK_M,
   output logic [NUM_MASTERS-1:0]     HREADY_M,
   output logic [32*NUM_MASTERS-1:0]  HRDATA_M,
   output logic [2*NUM_MASTERS-1:0]   HRESP_M,
   input  logic                       HREADY,
   input  logic [31:0]                HRDATA,
   input  logic [1:0]                 HRESP,
   output logic [1:0]                 HTRANS,
   output logic [31:0]                HADDR,
   output logic                       HWRITE,
   output logic [2:0]                 HSIZE,
   output logic [2:0]                 HBURST,
   output logic [3:0]                 HPROT,
   output logic                       HMASTLOCK,
   output logic [31:0]                HWDATA,
   output logic [GW-1:0]              grant
);

   localparam logic [GW-1:0] C_PARK  = PARK_MASTER[GW-1:0];
   localparam logic [GW-1:0] C_FORCE = FORCE_MASTER[GW-1:0];

   if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_num_masters
      $error("ahb_lite_arbiter_n: NUM_MASTERS must be in 2..8");
   end
   if (PARK_MASTER >= NUM_MASTERS || FORCE_MASTER >= NUM_MASTERS) begin : g_bad_master_idx
      $error("ahb_lite_arbiter_n: PARK_MASTER/FORCE_MASTER out of range");
   end

   logic [GW-1:0] grant_q, grant_d;
   logic [GW-1:0] downer_q, downer_d;
   logic [GW-1:0] last_q, last_d;
   logic [GW-1:0] pick;
   logic          handover;

   logic [NUM_MASTERS-1:0] req;
   logic [1:0]  htrans_a [NUM_MASTERS];
   logic [31:0] haddr_a  [NUM_MASTERS];
   logic [31:0] hwdata_a [NUM_MASTERS];
   logic [2:0]  hsize_a  [NUM_MASTERS];
   logic [2:0]  hburst_a [NUM_MASTERS];
   logic [3:0]  hprot_a  [NUM_MASTERS];

   for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_slice
      localparam logic [GW-1:0] C_IDX = GW'(i);
      assign htrans_a[i] = HTRANS_M[2*i +: 2];
      assign haddr_a[i]  = HADDR_M[32*i +: 32];
      assign hwdata_a[i] = HWDATA_M[32*i +: 32];
      assign hsize_a[i]  = HSIZE_M[3*i +: 3];
      assign hburst_a[i] = HBURST_M[3*i +: 3];
      assign hprot_a[i]  = HPROT_M[4*i +: 4];
      // NONSEQ/SEQ both have bit 1 set; BUSY and IDLE do not request the bus
      assign req[i]      = HTRANS_M[2*i+1];
      // A waiting master is stalled so it keeps its address phase on its own port
      assign HREADY_M[i] = (grant_q == C_IDX) ? HREADY : ~req[i];
      assign HRESP_M[2*i +: 2]   = (downer_q == C_IDX) ? HRESP : 2'b00;
      assign HRDATA_M[32*i +: 32] = HRDATA;
   end

   assign HTRANS    = htrans_a[grant_q];
   assign HADDR     = haddr_a[grant_q];
   assign HWRITE    = HWRITE_M[grant_q];
   assign HSIZE     = hsize_a[grant_q];
   assign HBURST    = hburst_a[grant_q];
   assign HPROT     = hprot_a[grant_q];
   assign HMASTLOCK = HMASTLOCK_M[grant_q];
   assign HWDATA    = hwdata_a[downer_q];
   assign grant     = grant_q;

   always_comb begin
      pick = grant_q;
      if (ARB_MODE == 0) begin
         for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (req[i]) pick = GW'(i);
         end
      end else begin
         // Scan downwards so the nearest requester after last_q is assigned last
         for (int k = NUM_MASTERS; k >= 1; k--) begin
            logic [GW-1:0] idx;
            idx = GW'((int'(last_q) + k) % NUM_MASTERS);
            if (req[idx]) pick = idx;
         end
      end
   end

   always_comb begin
      handover = HREADY && (htrans_a[grant_q] == 2'b00) && !HMASTLOCK_M[grant_q];
      grant_d  = grant_q;
      last_d   = last_q;
      downer_d = HREADY ? grant_q : downer_q;
      if (handover) begin
         if (force_req) begin
            grant_d = C_FORCE;
            if (req[C_FORCE]) last_d = C_FORCE;
         end else if (|req) begin
            grant_d = pick;
            last_d  = pick;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_q  <= C_PARK;
         downer_q <= C_PARK;
         last_q   <= C_PARK;
      end else begin
         grant_q  <= grant_d;
         downer_q <= downer_d;
         last_q   <= last_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_arbiter_n.sv
`default_nettype none
// Directed bench: instance A is 2-master fixed priority, instance B is 4-master round-robin;
// both share clock, reset, force_req and the slave-side response signals.
module tb_ahb_lite_arbiter_n;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, force_req, hready;
   logic [31:0] hrdata;
   logic [1:0]  hresp;
   int n_checks = 0;
   int n_fail   = 0;

   logic [3:0]  a_htrans;
   logic [63:0] a_haddr, a_hwdata, a_hrdata_m;
   logic [1:0]  a_hwrite, a_hlock, a_hready_m;
   logic [5:0]  a_hsize, a_hburst;
   logic [7:0]  a_hprot;
   logic [3:0]  a_hresp_m;
   logic [1:0]  a_HTRANS;
   logic [31:0] a_HADDR, a_HWDATA;
   logic        a_HWRITE, a_HMASTLOCK;
   logic [2:0]  a_HSIZE, a_HBURST;
   logic [3:0]  a_HPROT;
   logic [0:0]  a_grant;

   logic [7:0]   b_htrans;
   logic [127:0] b_haddr, b_hwdata, b_hrdata_m;
   logic [3:0]   b_hwrite, b_hlock, b_hready_m;
   logic [11:0]  b_hsize, b_hburst;
   logic [15:0]  b_hprot;
   logic [7:0]   b_hresp_m;
   logic [1:0]   b_HTRANS;
   logic [31:0]  b_HADDR, b_HWDATA;
   logic         b_HWRITE, b_HMASTLOCK;
   logic [2:0]   b_HSIZE, b_HBURST;
   logic [3:0]   b_HPROT;
   logic [1:0]   b_grant;

   logic [1:0] rr_exp [6] = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3};

   ahb_lite_arbiter_n #(.NUM_MASTERS(2), .ARB_MODE(0), .PARK_MASTER(0), .FORCE_MASTER(1)) dut_a (
      .clk(clk), .rst(rst), .force_req(force_req),
      .HTRANS_M(a_htrans), .HADDR_M(a_haddr), .HWDATA_M(a_hwdata), .HWRITE_M(a_hwrite),
      .HSIZE_M(a_hsize), .HBURST_M(a_hburst), .HPROT_M(a_hprot), .HMASTLOCK_M(a_hlock),
      .HREADY_M(a_hready_m), .HRDATA_M(a_hrdata_m), .HRESP_M(a_hresp_m),
      .HREADY(hready), .HRDATA(hrdata), .HRESP(hresp),
      .HTRANS(a_HTRANS), .HADDR(a_HADDR), .HWRITE(a_HWRITE), .HSIZE(a_HSIZE),
      .HBURST(a_HBURST), .HPROT(a_HPROT), .HMASTLOCK(a_HMASTLOCK), .HWDATA(a_HWDATA),
      .grant(a_grant)
   );

   ahb_lite_arbiter_n #(.NUM_MASTERS(4), .ARB_MODE(1), .PARK_MASTER(0), .FORCE_MASTER(1)) dut_b (
      .clk(clk), .rst(rst), .force_req(force_req),
      .HTRANS_M(b_htrans), .HADDR_M(b_haddr), .HWDATA_M(b_hwdata), .HWRITE_M(b_hwrite),
      .HSIZE_M(b_hsize), .HBURST_M(b_hburst), .HPROT_M(b_hprot), .HMASTLOCK_M(b_hlock),
      .HREADY_M(b_hready_m), .HRDATA_M(b_hrdata_m), .HRESP_M(b_hresp_m),
      .HREADY(hready), .HRDATA(hrdata), .HRESP(hresp),
      .HTRANS(b_HTRANS), .HADDR(b_HADDR), .HWRITE(b_HWRITE), .HSIZE(b_HSIZE),
      .HBURST(b_HBURST), .HPROT(b_HPROT), .HMASTLOCK(b_HMASTLOCK), .HWDATA(b_HWDATA),
      .grant(b_grant)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      cyc();
      rst = 1'b1;
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      n_checks++; if (a_grant !== 1'b0) begin n_fail++; $display("FAIL rst_a_grant: got %0d want 0", a_grant); end
      n_checks++; if (a_HTRANS !== 2'b00) begin n_fail++; $display("FAIL rst_a_htrans: got %b want 00", a_HTRANS); end
      n_checks++; if (a_HADDR !== 32'h8000_0000) begin n_fail++; $display("FAIL rst_a_haddr: got %h want 80000000", a_HADDR); end
      n_checks++; if (a_hready_m !== 2'b11) begin n_fail++; $display("FAIL rst_a_hready_m: got %b want 11", a_hready_m); end
      n_checks++; if (a_hresp_m !== 4'b0000) begin n_fail++; $display("FAIL rst_a_hresp_m: got %b want 0000", a_hresp_m); end
      n_checks++; if (b_grant !== 2'd0) begin n_fail++; $display("FAIL rst_b_grant: got %0d want 0", b_grant); end
      n_checks++; if (b_HADDR !== 32'h0000_0F00) begin n_fail++; $display("FAIL rst_b_haddr: got %h want 00000f00", b_HADDR); end
      n_checks++; if (b_hready_m !== 4'hF) begin n_fail++; $display("FAIL rst_b_hready_m: got %b want 1111", b_hready_m); end
      cyc();
      rst = 1'b0;
   endtask

   task automatic test_single_write();
      a_htrans = 4'b1010;
      a_hwrite = 2'b01;
      #1;
      n_checks++; if (a_HADDR !== 32'h8000_0000 || a_HTRANS !== 2'b10 || a_HWRITE !== 1'b1) begin n_fail++; $display("FAIL sw_addr_m0: got %h/%b/%b want 80000000/10/1", a_HADDR, a_HTRANS, a_HWRITE); end
      n_checks++; if (a_hready_m !== 2'b01) begin n_fail++; $display("FAIL sw_stall_m1: got %b want 01", a_hready_m); end
      cyc();
      a_htrans = 4'b1000;
      #1;
      n_checks++; if (a_HWDATA !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_hwdata: got %h want deadbeef", a_HWDATA); end
      n_checks++; if (a_hready_m !== 2'b01 || a_grant !== 1'b0) begin n_fail++; $display("FAIL sw_m0_idle: got %b/%0d want 01/0", a_hready_m, a_grant); end
      cyc();
      #1;
      n_checks++; if (a_grant !== 1'b1) begin n_fail++; $display("FAIL sw_grant_m1: got %0d want 1", a_grant); end
      n_checks++; if (a_HADDR !== 32'h0000_1000 || a_HTRANS !== 2'b10 || a_HWRITE !== 1'b0) begin n_fail++; $display("FAIL sw_addr_m1: got %h/%b/%b want 00001000/10/0", a_HADDR, a_HTRANS, a_HWRITE); end
      n_checks++; if (a_hready_m !== 2'b11) begin n_fail++; $display("FAIL sw_hready_m1: got %b want 11", a_hready_m); end
      n_checks++; if (a_HWDATA !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_hwdata_owner: got %h want deadbeef", a_HWDATA); end
      cyc();
      a_htrans = 4'b0000;
      #1;
      n_checks++; if (a_HWDATA !== 32'h5555_5555) begin n_fail++; $display("FAIL sw_hwdata_m1: got %h want 55555555", a_HWDATA); end
      cyc();
      #1;
      n_checks++; if (a_grant !== 1'b1) begin n_fail++; $display("FAIL sw_no_repark: got %0d want 1", a_grant); end
   endtask

   task automatic test_round_robin();
      logic [1:0] tr [4];
      logic [3:0] rdy;
      logic [1:0] prev;
      int nrec;
      tr[0] = 2'b10; tr[1] = 2'b00; tr[2] = 2'b10; tr[3] = 2'b10;
      nrec = 0;
      prev = 2'd0;
      for (int c = 0; c < 40 && nrec < 6; c++) begin
         b_htrans = {tr[3], tr[2], tr[1], tr[0]};
         #1;
         if (c == 0 || b_grant !== prev) begin
            n_checks++;
            if (b_grant !== rr_exp[nrec]) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d want %0d", nrec, b_grant, rr_exp[nrec]); end
            nrec++;
            prev = b_grant;
         end
         rdy = b_hready_m;
         cyc();
         for (int i = 0; i < 4; i++) begin
            if (i != 1) tr[i] = (tr[i] == 2'b10 && rdy[i]) ? 2'b00 : 2'b10;
         end
      end
      if (nrec < 6) begin n_checks++; n_fail++; $display("FAIL rr_timeout: got %0d grants want 6", nrec); end
      b_htrans = 8'h00;
      cyc();
   endtask

   task automatic test_lock_force();
      pulse_reset();
      a_htrans = 4'b0010; a_hburst = 6'b000_011; a_hlock = 2'b01;
      #1;
      n_checks++; if (a_grant !== 1'b0 || a_HMASTLOCK !== 1'b1 || a_HBURST !== 3'b011) begin n_fail++; $display("FAIL lk_start: got %0d/%b/%b want 0/1/011", a_grant, a_HMASTLOCK, a_HBURST); end
      cyc();
      a_htrans = 4'b0011; force_req = 1'b1;
      #1;
      n_checks++; if (a_grant !== 1'b0 || a_hready_m !== 2'b11) begin n_fail++; $display("FAIL lk_force_mid: got %0d/%b want 0/11", a_grant, a_hready_m); end
      cyc(); #1;
      cyc(); #1;
      n_checks++; if (a_grant !== 1'b0 || a_HTRANS !== 2'b11) begin n_fail++; $display("FAIL lk_burst_hold: got %0d/%b want 0/11", a_grant, a_HTRANS); end
      cyc();
      a_htrans = 4'b0000;
      #1;
      cyc();
      a_hlock = 2'b00;
      #1;
      n_checks++; if (a_grant !== 1'b0) begin n_fail++; $display("FAIL lk_locked_idle: got %0d want 0", a_grant); end
      cyc();
      a_htrans = 4'b0010; a_hburst = 6'b000_000;
      #1;
      n_checks++; if (a_grant !== 1'b1 || a_hready_m !== 2'b10 || a_HADDR !== 32'h0000_1000) begin n_fail++; $display("FAIL lk_forced: got %0d/%b/%h want 1/10/00001000", a_grant, a_hready_m, a_HADDR); end
      cyc();
      #1;
      n_checks++; if (a_grant !== 1'b1) begin n_fail++; $display("FAIL lk_force_blocks: got %0d want 1", a_grant); end
      force_req = 1'b0;
      cyc();
      #1;
      n_checks++; if (a_grant !== 1'b0 || a_HTRANS !== 2'b10) begin n_fail++; $display("FAIL lk_release: got %0d/%b want 0/10", a_grant, a_HTRANS); end
      a_htrans = 4'b0000;
      cyc();
   endtask

   task automatic test_error_wait();
      pulse_reset();
      a_htrans = 4'b1000; a_hwrite = 2'b00;
      #1;
      n_checks++; if (a_grant !== 1'b0 || a_hready_m !== 2'b01) begin n_fail++; $display("FAIL er_req: got %0d/%b want 0/01", a_grant, a_hready_m); end
      cyc(); #1;
      n_checks++; if (a_grant !== 1'b1 || a_HADDR !== 32'h0000_1000) begin n_fail++; $display("FAIL er_addr: got %0d/%h want 1/00001000", a_grant, a_HADDR); end
      cyc();
      a_htrans = 4'b0010; hready = 1'b0; hresp = 2'b00;
      #1;
      n_checks++; if (a_hready_m !== 2'b00 || a_hresp_m !== 4'b0000) begin n_fail++; $display("FAIL er_wait: got %b/%b want 00/0000", a_hready_m, a_hresp_m); end
      cyc();
      cyc();
      hresp = 2'b01;
      #1;
      n_checks++; if (a_hresp_m !== 4'b0100) begin n_fail++; $display("FAIL er_resp1: got %b want 0100", a_hresp_m); end
      cyc();
      hready = 1'b1; hrdata = 32'h1234_5678;
      #1;
      n_checks++; if (a_hresp_m !== 4'b0100) begin n_fail++; $display("FAIL er_resp2: got %b want 0100", a_hresp_m); end
      n_checks++; if (a_hrdata_m !== {2{32'h1234_5678}}) begin n_fail++; $display("FAIL er_hrdata: got %h want 1234567812345678", a_hrdata_m); end
      n_checks++; if (a_hready_m !== 2'b10 || a_grant !== 1'b1) begin n_fail++; $display("FAIL er_no_early_switch: got %b/%0d want 10/1", a_hready_m, a_grant); end
      cyc();
      hresp = 2'b00;
      #1;
      n_checks++; if (a_grant !== 1'b0 || a_HADDR !== 32'h8000_0000 || a_hresp_m !== 4'b0000) begin n_fail++; $display("FAIL er_after: got %0d/%h/%b want 0/80000000/0000", a_grant, a_HADDR, a_hresp_m); end
      a_htrans = 4'b0000;
      cyc();
   endtask

   task automatic test_reset_mid();
      pulse_reset();
      b_htrans = 8'b0010_0000; b_hwrite = 4'b0100;
      #1;
      n_checks++; if (b_hready_m !== 4'b1011) begin n_fail++; $display("FAIL rm_stall: got %b want 1011", b_hready_m); end
      cyc(); #1;
      n_checks++; if (b_grant !== 2'd2 || b_HADDR !== 32'h0000_2000) begin n_fail++; $display("FAIL rm_grant2: got %0d/%h want 2/00002000", b_grant, b_HADDR); end
      cyc();
      b_htrans = 8'h00;
      #1;
      n_checks++; if (b_HWDATA !== 32'hCAFE_0002) begin n_fail++; $display("FAIL rm_dphase: got %h want cafe0002", b_HWDATA); end
      #1 rst = 1'b1;
      #1;
      n_checks++; if (b_grant !== 2'd0 || b_HWDATA !== 32'hCAFE_0000 || b_HADDR !== 32'h0000_0F00) begin n_fail++; $display("FAIL rm_async: got %0d/%h/%h want 0/cafe0000/00000f00", b_grant, b_HWDATA, b_HADDR); end
      cyc();
      rst = 1'b0;
      b_htrans = 8'b1000_0000;
      #1;
      n_checks++; if (b_grant !== 2'd0 || b_hready_m !== 4'b0111) begin n_fail++; $display("FAIL rm_resume_req: got %0d/%b want 0/0111", b_grant, b_hready_m); end
      cyc(); #1;
      n_checks++; if (b_grant !== 2'd3 || b_HADDR !== 32'h0000_3000) begin n_fail++; $display("FAIL rm_resume_grant: got %0d/%h want 3/00003000", b_grant, b_HADDR); end
      b_htrans = 8'h00;
      cyc();
   endtask

   initial begin
      rst = 1'b1; force_req = 1'b0; hready = 1'b1; hrdata = 32'h0; hresp = 2'b00;
      a_htrans = '0; a_hwrite = '0; a_hlock = '0; a_hsize = '0; a_hburst = '0; a_hprot = '0;
      a_haddr  = {32'h0000_1000, 32'h8000_0000};
      a_hwdata = {32'h5555_5555, 32'hDEAD_BEEF};
      b_htrans = '0; b_hwrite = '0; b_hlock = '0; b_hsize = '0; b_hburst = '0; b_hprot = '0;
      b_haddr  = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0F00};
      b_hwdata = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
      test_reset();
      test_single_write();
      test_round_robin();
      test_lock_force();
      test_error_wait();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
